// File: rtl/sext_block_accumulator_if.sv
// rtl/sext_block_accumulator_if.sv - sample-in / block-sum-out handshake bundle for sext_block_accumulator
interface sext_block_accumulator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  clear;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_sum;
  logic                  out_sat;

  modport master (
    output in_valid, in_data, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_sat
  );

  modport slave (
    input  in_valid, in_data, clear, out_ready,
    output in_ready, out_valid, out_sum, out_sat
  );
endinterface

// File: rtl/sext_block_accumulator.sv
// rtl/sext_block_accumulator.sv - signed block accumulator of sign-extended samples; ACCUM_SAT_EN enables saturating adds
module sext_block_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int BLOCK_LEN  = 8
) (
  input  logic clk,
  input  logic rst_n,
  sext_block_accumulator_if.slave bus
);
  localparam int            CW   = $clog2(BLOCK_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH-1:0] add_res;
  logic                 accept;
  logic                 emit;

  assign sample_ext = ACC_WIDTH'($signed(bus.in_data));
  assign accept     = bus.in_valid & bus.in_ready;
  assign emit       = out_valid_q & bus.out_ready;

`ifdef ACCUM_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] wide_sum;
  logic               clamp;
  logic               sat_q, sat_d;
  logic               out_sat_q, out_sat_d;

  // One guard bit: overflow shows as disagreement between the guard and the sign bit.
  assign wide_sum = {acc_q[ACC_WIDTH-1], acc_q} + {sample_ext[ACC_WIDTH-1], sample_ext};
  assign clamp    = wide_sum[ACC_WIDTH] ^ wide_sum[ACC_WIDTH-1];
  assign add_res  = !clamp ? wide_sum[ACC_WIDTH-1:0]
                           : (wide_sum[ACC_WIDTH] ? SAT_MIN : SAT_MAX);

  always_comb begin
    sat_d     = sat_q;
    out_sat_d = out_sat_q;
    if (bus.clear) begin
      sat_d     = 1'b0;
      out_sat_d = 1'b0;
    end else if (accept) begin
      if (count_q == LAST) begin
        out_sat_d = sat_q | clamp;
        sat_d     = 1'b0;
      end else begin
        sat_d = sat_q | clamp;
      end
    end else if (emit) begin
      out_sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q     <= 1'b0;
      out_sat_q <= 1'b0;
    end else begin
      sat_q     <= sat_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign bus.out_sat = out_sat_q;
`else
  assign add_res     = acc_q + sample_ext;
  assign bus.out_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // IDLE keeps acc and count at zero, so it shares the ACCUM path; BLOCK_LEN=1 goes straight to HOLD.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    if (bus.clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            if (count_q == LAST) begin
              state_d     = HOLD;
              sum_d       = add_res;
              out_valid_d = 1'b1;
              acc_d       = '0;
              count_d     = '0;
            end else begin
              state_d = ACCUM;
              acc_d   = add_res;
              count_d = count_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (emit) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
endmodule

// File: tb/tb_sext_block_accumulator.sv
// tb/tb_sext_block_accumulator.sv - directed scoreboard bench for sext_block_accumulator (ACCUM_SAT_EN aware)
module tb_sext_block_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [39:0] model_sum = '0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  sext_block_accumulator_if #(.DATA_WIDTH(32), .ACC_WIDTH(40)) bus ();
  sext_block_accumulator_if #(.DATA_WIDTH(32), .ACC_WIDTH(32)) bus32 ();

  sext_block_accumulator #(.DATA_WIDTH(32), .ACC_WIDTH(40), .BLOCK_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  sext_block_accumulator #(.DATA_WIDTH(32), .ACC_WIDTH(32), .BLOCK_LEN(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rep(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && w < 20) begin
        tick();
        w++;
      end
      if (w == 20) chk("ready_timeout", {63'b0, bus.in_ready}, 64'd1);
      tick();
      model_sum = model_sum + {{8{d[31]}}, d};
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic push_exp();
    exp_q.push_back(model_sum);
    model_sum = '0;
  endtask

  task automatic finish_block(input string tag);
    logic [39:0] e;
    chk({tag, "_valid"}, {63'b0, bus.out_valid}, 64'd1);
    chk({tag, "_bubble"}, {63'b0, bus.in_ready}, 64'd0);
    chk({tag, "_sat"}, {63'b0, bus.out_sat}, 64'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd0, {32'b0, checks});
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, {24'b0, bus.out_sum}, {24'b0, e});
    end
    if (bus.out_ready) begin
      tick();
      chk({tag, "_drop"}, {63'b0, bus.out_valid}, 64'd0);
      chk({tag, "_ready"}, {63'b0, bus.in_ready}, 64'd1);
    end
  endtask

  initial begin
    logic [39:0] held;
    bus.in_valid = 1'b1; bus.in_data = 32'd1; bus.clear = 1'b0; bus.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.clear = 1'b0; bus32.out_ready = 1'b1;

    // reset held with a valid sample on the bus
    repeat (3) tick();
    chk("rst_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_sum", {24'b0, bus.out_sum}, 64'd0);
    chk("rst_sat", {63'b0, bus.out_sat}, 64'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    chk("rst_ready", {63'b0, bus.in_ready}, 64'd1);

    // basic block
    send_rep(32'h0000_0001, 8);
    push_exp();
    chk("basic_const", {24'b0, bus.out_sum}, 64'h00_0000_0008);
    finish_block("basic");

    // signed mix
    send_rep(32'hFFFF_8000, 4);
    send_rep(32'h0000_0001, 4);
    push_exp();
    chk("mix_const", {24'b0, bus.out_sum}, 64'hFF_FFFE_0004);
    finish_block("mix");

    // backpressure with in_valid held during HOLD
    bus.out_ready = 1'b0;
    send_rep(32'h0000_0009, 8);
    push_exp();
    held = bus.out_sum;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", {63'b0, bus.in_ready}, 64'd0);
      chk("bp_valid", {63'b0, bus.out_valid}, 64'd1);
      chk("bp_stable", {24'b0, bus.out_sum}, {24'b0, held});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    finish_block("bp");
    send_rep(32'h0000_0003, 8);
    push_exp();
    finish_block("bp_fresh");

    // clear mid-block, with a sample presented alongside clear
    send_rep(32'h0000_0005, 3);
    model_sum = '0;
    bus.in_valid = 1'b1; bus.in_data = 32'd7; bus.clear = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.clear = 1'b0;
    chk("clr_valid", {63'b0, bus.out_valid}, 64'd0);
    send_rep(32'h0000_0002, 8);
    push_exp();
    chk("clr_const", {24'b0, bus.out_sum}, 64'd16);
    finish_block("clr");

    // clear in HOLD discards the pending sum
    bus.out_ready = 1'b0;
    send_rep(32'h0000_0001, 8);
    model_sum = '0;
    chk("clrhold_pre", {63'b0, bus.out_valid}, 64'd1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clrhold_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("clrhold_ready", {63'b0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;

    // asynchronous reset pulse mid-block
    send_rep(32'h0000_0005, 3);
    model_sum = '0;
    rst_n = 1'b0;
    #1;
    chk("arst_sum", {24'b0, bus.out_sum}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_rep(32'h0000_0002, 8);
    push_exp();
    chk("arst_const", {24'b0, bus.out_sum}, 64'd16);
    finish_block("arst");

    // overflow on the 32-bit accumulator instance
    bus32.in_valid = 1'b1;
    bus32.in_data  = 32'h7FFF_FFFF;
    repeat (8) tick();
    bus32.in_valid = 1'b0;
    chk("ovf_valid", {63'b0, bus32.out_valid}, 64'd1);
`ifdef ACCUM_SAT_EN
    chk("ovf_sum", {32'b0, bus32.out_sum}, 64'h7FFF_FFFF);
    chk("ovf_sat", {63'b0, bus32.out_sat}, 64'd1);
`else
    chk("ovf_sum", {32'b0, bus32.out_sum}, 64'hFFFF_FFF8);
    chk("ovf_sat", {63'b0, bus32.out_sat}, 64'd0);
`endif
    tick();
    chk("ovf_emit", {63'b0, bus32.out_valid}, 64'd0);
    chk("ovf_sat_clr", {63'b0, bus32.out_sat}, 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sext_block_accumulator.md
Name: sext_block_accumulator

Overview:
- Downstream consumer of the sign_extend stage.
- Takes 32-bit sign-extended samples over a valid/ready handshake and accumulates them into signed blocks of BLOCK_LEN samples.
- Presents each block sum on a held output handshake.
- Used to reduce synchronized sample streams to block sums before crossing to the slow domain.

Parameters:
- DATA_WIDTH, 32: width of in_data; matches the sign_extend NUM_OUTPUTS.
- ACC_WIDTH, 40: accumulator/out_sum width. Must be >= DATA_WIDTH.
- BLOCK_LEN, 8: samples per block. Must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  DATA_WIDTH  signed two's-complement sample from sign_extend.
- clear  input  1  synchronous abort of the current block.
- out_valid  output  1  out_sum valid.
- out_ready  input  1  consumer accepts out_sum.
- out_sum  output  ACC_WIDTH  signed block sum.
- out_sat  output  1  block saturated. Active only with ACCUM_SAT_EN; tied 0 otherwise.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, acc=0, count=0.
  - out_valid=0, out_sum=0, out_sat=0.
  - in_ready=1 once reset is released.
- Handshakes:
  - accept = in_valid & in_ready.
  - emit = out_valid & out_ready.
  - in_ready = (state != HOLD), combinational from state only.
  - out_valid and out_sum are registered.
- Width rule: in_data is sign-extended to ACC_WIDTH before adding. The sum wraps modulo 2^ACC_WIDTH unless ACCUM_SAT_EN is defined.
- FSM states: IDLE (count=0, acc=0), ACCUM, HOLD.
  - IDLE --accept--> ACCUM. count=1, acc=sample.
  - If BLOCK_LEN=1: IDLE --accept--> HOLD directly.
  - ACCUM --accept, count<BLOCK_LEN-1--> ACCUM. count++, acc+=sample.
  - ACCUM --accept, count==BLOCK_LEN-1--> HOLD. out_sum<=acc+sample, out_valid<=1, acc<=0, count<=0.
  - HOLD: out_sum and out_valid stable while out_ready=0. in_valid is ignored (no accept).
  - HOLD --emit--> IDLE. out_valid=0 in the next cycle; out_sum retains its last value.
- Latency:
  - out_valid rises the cycle after the BLOCK_LEN-th accept.
  - Exactly one bubble cycle between blocks (in_ready=0 while in HOLD).
- clear:
  - Synchronous; highest priority below reset.
  - Effect: state=IDLE, acc=0, count=0, out_valid=0, out_sat=0.
  - A sample presented with clear in the same cycle is dropped.
  - clear in HOLD discards the pending sum.
- rst_n asserted mid-block or in HOLD: everything returns to reset values immediately. The partial sum is lost.
- count width: clog2(BLOCK_LEN+1). count never exceeds BLOCK_LEN-1.

Optional Feature:
- Macro: ACCUM_SAT_EN.
- Defined:
  - Each addition saturates to the signed ACC_WIDTH range: max 2^(ACC_WIDTH-1)-1, min -2^(ACC_WIDTH-1).
  - Any clamp within a block sets a sticky per-block flag.
  - The flag is presented on out_sat with out_sum, and cleared on emit, clear or reset.
- Not defined: modular wrap; out_sat constant 0; no saturation logic synthesized.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_sum=0, out_sat=0. After release, in_ready=1.
- Basic block: out_ready=1, 8 back-to-back samples 32'h0000_0001 -> out_valid=1 exactly 1 cycle after the 8th accept, out_sum=40'h00_0000_0008. in_ready=0 for that one cycle.
- Signed mix: 4x 32'hFFFF_8000 then 4x 32'h0000_0001 -> out_sum=40'hFF_FFFE_0004 (-131068).
- Backpressure: complete a block with out_ready=0 for 5 cycles while in_valid=1 -> out_sum stable, in_ready=0, no samples accepted. On out_ready=1, out_valid=0 next cycle. The next 8 samples form a fresh sum.
- clear / reset mid-block:
  - 3 samples of 5, then clear (with a valid sample), then 8 samples of 2 -> out_sum=16.
  - Repeat using a rst_n pulse in place of clear -> out_sum=16.
- Overflow (ACC_WIDTH=32, 8x 32'h7FFF_FFFF):
  - With ACCUM_SAT_EN: out_sum=32'h7FFF_FFFF, out_sat=1.
  - Without ACCUM_SAT_EN: out_sum=32'hFFFF_FFF8, out_sat=0.
